// File: rtl/uart_responder.sv
// Byte responder between UART RX and TX: queues received bytes and answers each one,
// echoing ordinary bytes and replacing a status query with an occupancy/overflow byte.
module uart_responder #(
    parameter int         DEPTH      = 8,
    parameter logic [7:0] STATUS_CMD = 8'h3F
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     start_tx,
    output logic [7:0]               data_in,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop;
    logic            push_req;
    logic            full;
    logic            accept;
    logic            is_status;
    logic [7:0]      entry;

    // Status reply carries the pre-push overflow flag and low occupancy nibble.
    function automatic logic [7:0] status_byte(input logic ovf, input logic [CW-1:0] cnt);
        logic [7:0] c8;
        c8 = 8'(cnt);
        return {ovf, 3'b000, c8[3:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (tx_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && en && (fifo_count != '0) && !tx_busy;
        push_req  = rx_done && en;
        full      = (fifo_count == CW'(DEPTH));
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        accept    = push_req && (!full || pop);
        is_status = (rx_data == STATUS_CMD);
        entry     = is_status ? status_byte(overflow, fifo_count) : rx_data;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_tx   <= 1'b0;
            data_in    <= 8'h00;
            fifo_count <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            start_tx <= (next_state == START) && (state == IDLE);
            if (pop) begin
                data_in <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !accept)      overflow <= 1'b1;
            else if (accept && is_status) overflow <= 1'b0;
        end
    end
endmodule

// File: doc/uart_responder.md
# uart_responder

Byte-level responder between the UART receiver's completed-byte outputs and the UART transmitter's start/data inputs. It buffers received bytes in a small FIFO and replies to the remote end one byte at a time. Ordinary bytes are echoed back unchanged; a status-query byte is answered with a status byte instead. Together with the UART top it makes the device the answering end of the link.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..16.
- STATUS_CMD, 8'h3F: received byte value that triggers a status reply.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  responder enable.
- rx_done  in  1  one-cycle pulse: `rx_data` holds a new byte.
- rx_data  in  8  received byte; sampled only when `rx_done`=1.
- tx_busy  in  1  transmitter is sending a frame.
- tx_done  in  1  one-cycle pulse at end of a transmitted frame.
- start_tx  out  1  one-cycle request to the transmitter.
- data_in  out  8  byte presented to the transmitter.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- **Push.** On `rx_done`=1 with `en`=1, one entry is written:
  - If `rx_data` != STATUS_CMD, the entry is `rx_data`.
  - If `rx_data` == STATUS_CMD, the entry is {overflow, 3'b000, fifo_count[3:0]}. Both `overflow` and `fifo_count` are the values before this push. `overflow` clears on the same edge.
- **Full.** When `fifo_count`==DEPTH and no pop occurs in the same cycle, the push is dropped and `overflow` is set to 1. A dropped STATUS_CMD does not clear `overflow`.
- **Push and pop together.** Both take effect; `fifo_count` is unchanged. When full, the simultaneous pop frees a slot, so the push is accepted.
- **Disabled.** When `en`=0, `rx_done` is ignored and no new pop starts. A frame already in progress runs to completion.
- **FSM, IDLE.** If `en`=1, the FIFO is non-empty and `tx_busy`=0: pop the head into the `data_in` register, set `start_tx`, go to START.
- **FSM, START.** `start_tx`=1 for this cycle; go to WAIT.
- **FSM, WAIT.** Hold `data_in`. On `tx_done`=1, go to IDLE.
- Only one byte is outstanding at a time. `data_in` is stable from `start_tx` until `tx_done`.
- Read and write pointers wrap modulo DEPTH. `fifo_count` ranges 0..DEPTH.

## Timing
- **Reset values.** `start_tx`=0, `data_in`=8'h00, `fifo_count`=0, `overflow`=0, state=IDLE, pointers=0.
- **Reset mid-operation.** An assertion of `rst_n` at any time returns all of the above to their reset values immediately, regardless of clock. FIFO contents are discarded.
- All outputs are registered.
- **Push latency.** With `rx_done` high in cycle N, `fifo_count` increments in cycle N+1.
- **Echo latency.** With an empty FIFO, IDLE state and `tx_busy`=0, `rx_done` in cycle N gives `start_tx`=1 and a valid `data_in` in cycle N+2. `start_tx` is high for exactly one cycle.
- The pop decision in IDLE samples `tx_busy` in the same cycle.
- `tx_done` is only acted on in WAIT; a `tx_done` in IDLE or START is ignored.
- After `tx_done` in cycle M, the next `start_tx` occurs no earlier than M+2.

## Test plan
- **Single echo.** Reset, `en`=1, `rx_done` with 8'hA5 in cycle N → `fifo_count`=1 in N+1; `start_tx`=1 and `data_in`=8'hA5 in N+2; `tx_done` 20 cycles later → IDLE, `fifo_count`=0.
- **Ordering.** Burst of 8'h01..8'h05 on consecutive `rx_done` pulses while the transmitter is held busy → bytes transmitted in order 01,02,03,04,05, each `start_tx` following the previous `tx_done`.
- **Overflow then status.** With DEPTH=8, push 9 bytes with `tx_busy` held high → `fifo_count`=8, `overflow`=1. Then release `tx_busy` and pop one byte → 7 remain. Send 8'h3F → 8'h87 is queued and `overflow`=0; it is transmitted after the 7 earlier bytes.
- **Status when empty.** After reset, send 8'h3F → `data_in`=8'h00 transmitted.
- **Enable gating.** `en`=0 with 3 bytes queued → no `start_tx`, and an `rx_done` in this window leaves `fifo_count` unchanged. Set `en`=1 → the 3 bytes drain.
- **Reset mid-frame.** Drop `rst_n` while in WAIT with 4 bytes queued → all outputs return to reset values asynchronously. After release, no `start_tx` until a new `rx_done`.
